// File: rtl/fetch_ctrl.sv
// fetch_ctrl: sequences fetch against a variable-latency imem (req/ready) and buffers one instruction for decode.
// Latency: an imem hit is forwarded to IF/ID in the same cycle; a response held during a stall is delivered
//          one or more cycles later. Backpressure: stall_D parks the response in hold_buf, and a new request waits until it drains.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   imem_ready, imem_rdata     imem response handshake and data
//   stall_D                    decode hazard, IF/ID must hold
//   branch_taken               redirect request (PCBranch_F valid this cycle)
//   imem_req                   imem request; the fetch address must stay stable while it is high
//   enable_F, PCSrc_F          fetch PC advance / PC redirect select
//   valid_D, flush_D, instr_D  IF/ID capture strobe, invalidate, instruction
//   perf_stall_cyc, perf_redirects   saturating counters, present only with FETCH_CTRL_PERF_EN
//
// Build option: define FETCH_CTRL_PERF_EN to add the performance counters.

module fetch_ctrl #(
  parameter int N  = 64,
  parameter int IW = 32,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          imem_ready,
  input  logic [IW-1:0] imem_rdata,
  input  logic          stall_D,
  input  logic          branch_taken,
  output logic          imem_req,
  output logic          enable_F,
  output logic          PCSrc_F,
  output logic          valid_D,
  output logic          flush_D,
`ifdef FETCH_CTRL_PERF_EN
  output logic [CW-1:0] perf_stall_cyc,
  output logic [CW-1:0] perf_redirects,
`endif
  output logic [IW-1:0] instr_D
);

  // The PC must at least hold a word-aligned byte address.
  if (N < 3) begin : g_bad_n
    $error("fetch_ctrl: N too small for a byte-addressed PC");
  end

  typedef enum logic [1:0] {IDLE, WAIT, HOLD, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] hold_buf;
  logic          hold_load;

  // Outputs are decoded from the current state and the inputs. Every branch below
  // tests branch_taken first, so a redirect overrides both stall_D and imem_ready.
  always_comb begin
    state_nxt = state;
    hold_load = 1'b0;
    imem_req  = 1'b0;
    enable_F  = 1'b0;
    PCSrc_F   = 1'b0;
    valid_D   = 1'b0;
    flush_D   = 1'b0;
    instr_D   = '0;
    if (!reset) begin
      unique case (state)
        // One bubble after reset; an imem response arriving here is ignored.
        IDLE: state_nxt = WAIT;
        WAIT: begin
          imem_req = 1'b1;
          if (branch_taken) begin
            PCSrc_F = 1'b1;
            flush_D = 1'b1;
            // Without a response the old transaction is still outstanding, so it has to drain first.
            state_nxt = imem_ready ? WAIT : DRAIN;
          end else if (imem_ready && !stall_D) begin
            valid_D  = 1'b1;
            instr_D  = imem_rdata;
            enable_F = 1'b1;
          end else if (imem_ready) begin
            hold_load = 1'b1;
            state_nxt = HOLD;
          end
        end
        HOLD: begin
          if (branch_taken) begin
            PCSrc_F   = 1'b1;
            flush_D   = 1'b1;
            state_nxt = WAIT;
          end else if (!stall_D) begin
            valid_D   = 1'b1;
            instr_D   = hold_buf;
            enable_F  = 1'b1;
            state_nxt = WAIT;
          end
        end
        DRAIN: begin
          // A redirect may still retarget the PC while the stale response is pending.
          PCSrc_F = branch_taken;
          flush_D = branch_taken;
          if (imem_ready) state_nxt = WAIT;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      hold_buf <= '0;
    end else begin
      state <= state_nxt;
      if (hold_load) hold_buf <= imem_rdata;
    end
  end

`ifdef FETCH_CTRL_PERF_EN
  logic stall_evt, redir_evt;
  assign stall_evt = ((state == WAIT) && !imem_ready) || ((state == HOLD) && stall_D);
  assign redir_evt = branch_taken && (state != IDLE);

  // Both counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cyc <= '0;
      perf_redirects <= '0;
    end else begin
      if (stall_evt && (perf_stall_cyc != '1)) perf_stall_cyc <= perf_stall_cyc + 1'b1;
      if (redir_evt && (perf_redirects != '1)) perf_redirects <= perf_redirects + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed vectors with hand-computed expectations for fetch_ctrl.
// Latency: inputs change on the falling edge, and outputs are sampled 1 time unit later.
// Backpressure: imem_ready and stall_D are driven directly by each vector.

module tb_fetch_ctrl;
  localparam int IW = 32;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          imem_ready;
  logic [IW-1:0] imem_rdata;
  logic          stall_D;
  logic          branch_taken;
  logic          imem_req, enable_F, PCSrc_F, valid_D, flush_D;
  logic [IW-1:0] instr_D;
`ifdef FETCH_CTRL_PERF_EN
  logic [CW-1:0] perf_stall_cyc, perf_redirects;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  fetch_ctrl #(.N(64), .IW(IW), .CW(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .stall_D      (stall_D),
    .branch_taken (branch_taken),
    .imem_req     (imem_req),
    .enable_F     (enable_F),
    .PCSrc_F      (PCSrc_F),
    .valid_D      (valid_D),
    .flush_D      (flush_D),
`ifdef FETCH_CTRL_PERF_EN
    .perf_stall_cyc (perf_stall_cyc),
    .perf_redirects (perf_redirects),
`endif
    .instr_D      (instr_D)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Applies one input vector at the falling edge and lets combinational outputs settle.
  task automatic drive(input logic rst, input logic rdy, input logic [IW-1:0] rd,
                       input logic stl, input logic br);
    @(negedge clk);
    reset        = rst;
    imem_ready   = rdy;
    imem_rdata   = rd;
    stall_D      = stl;
    branch_taken = br;
    #1;
  endtask

  // Checks all control outputs at once, packed as {req, en, pcsrc, valid, flush}.
  task automatic check_ctl(input string tag, input logic [4:0] exp, input logic [IW-1:0] exp_instr);
    check({tag, ".ctl"}, {59'd0, imem_req, enable_F, PCSrc_F, valid_D, flush_D}, {59'd0, exp});
    check({tag, ".instr"}, {32'd0, instr_D}, {32'd0, exp_instr});
  endtask

  initial begin
    reset = 1'b1; imem_ready = 1'b0; imem_rdata = '0; stall_D = 1'b0; branch_taken = 1'b0;

    // While in reset, outputs stay 0 even with a response and a branch present.
    drive(1, 1, 32'h1111_1111, 0, 1);
    check_ctl("reset", 5'b00000, 32'h0);
    drive(1, 1, 32'h1111_1111, 0, 0);

    // Case 1: one IDLE bubble that ignores the response and the branch, then streaming hits.
    drive(0, 1, 32'h2222_2222, 0, 1);
    check_ctl("idle", 5'b00000, 32'h0);
    drive(0, 1, 32'hA000_0001, 0, 0);
    check_ctl("hit0", 5'b11010, 32'hA000_0001);
    drive(0, 1, 32'hA000_0002, 0, 0);
    check_ctl("hit1", 5'b11010, 32'hA000_0002);
    drive(0, 1, 32'hA000_0003, 0, 0);
    check_ctl("hit2", 5'b11010, 32'hA000_0003);

    // Case 2: three miss cycles, then a hit.
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 32'hDEAD_0000, 0, 0);
      check_ctl("miss", 5'b10000, 32'h0);
    end
    drive(0, 1, 32'hB000_0004, 0, 0);
    check_ctl("miss_hit", 5'b11010, 32'hB000_0004);

    // Case 3: hit under stall goes to HOLD, and the buffer is delivered once decode frees up.
    drive(0, 1, 32'hD503_201F, 1, 0);
    check_ctl("stall_cap", 5'b10000, 32'h0);
    drive(0, 1, 32'h5555_5555, 1, 0);
    check_ctl("hold_stall", 5'b00000, 32'h0);
    drive(0, 1, 32'h6666_6666, 0, 0);
    check_ctl("hold_rel", 5'b01010, 32'hD503_201F);
    drive(0, 0, 32'h0, 0, 0);
    check_ctl("after_hold", 5'b10000, 32'h0);

    // Case 4: redirect with a response outstanding goes to DRAIN, and the stale data is discarded.
    drive(0, 0, 32'h0, 0, 1);
    check_ctl("br_miss", 5'b10101, 32'h0);
    drive(0, 0, 32'h0, 0, 0);
    check_ctl("drain0", 5'b00000, 32'h0);
    drive(0, 1, 32'h7777_7777, 0, 0);
    check_ctl("drain_rdy", 5'b00000, 32'h0);
    drive(0, 0, 32'h0, 0, 0);
    check_ctl("post_drain", 5'b10000, 32'h0);

    // A redirect inside DRAIN retargets the PC but stays in DRAIN.
    drive(0, 0, 32'h0, 0, 1);
    check_ctl("br_miss2", 5'b10101, 32'h0);
    drive(0, 0, 32'h0, 0, 1);
    check_ctl("drain_br", 5'b00101, 32'h0);
    drive(0, 1, 32'h8888_8888, 0, 0);
    check_ctl("drain_rdy2", 5'b00000, 32'h0);

    // Case 5: a redirect beats both stall_D and imem_ready, and the FSM stays in WAIT.
    drive(0, 1, 32'h9999_9999, 1, 1);
    check_ctl("br_stall_hit", 5'b10101, 32'h0);
    drive(0, 1, 32'hC000_0005, 0, 0);
    check_ctl("br_stay_wait", 5'b11010, 32'hC000_0005);

    // A redirect in HOLD drops the buffer and returns to WAIT.
    drive(0, 1, 32'hEEEE_EEEE, 1, 0);
    drive(0, 0, 32'h0, 1, 1);
    check_ctl("hold_br", 5'b00101, 32'h0);
    drive(0, 0, 32'h0, 0, 0);
    check_ctl("hold_br_wait", 5'b10000, 32'h0);

    // Reset asserted in DRAIN returns to IDLE.
    drive(0, 0, 32'h0, 0, 1);
    drive(1, 0, 32'h0, 0, 0);
    check_ctl("rst_in_drain", 5'b00000, 32'h0);
    drive(0, 1, 32'h1234_5678, 0, 0);
    check_ctl("rst_idle", 5'b00000, 32'h0);
    drive(0, 1, 32'h1234_5678, 0, 0);
    check_ctl("rst_wait_hit", 5'b11010, 32'h1234_5678);

`ifdef FETCH_CTRL_PERF_EN
    // Case 6: 5 miss cycles and 2 redirects (taken on hits, so they add no stall cycles).
    drive(1, 0, 32'h0, 0, 0);
    drive(0, 0, 32'h0, 0, 1);          // IDLE: this branch is not counted
    check("perf_stall_rst", {32'd0, perf_stall_cyc}, 64'd0);
    check("perf_redir_rst", {32'd0, perf_redirects}, 64'd0);
    for (int i = 0; i < 5; i++) drive(0, 0, 32'h0, 0, 0);
    drive(0, 1, 32'h0, 0, 1);
    drive(0, 1, 32'h0, 0, 1);
    drive(0, 1, 32'h0, 0, 0);
    check("perf_stall", {32'd0, perf_stall_cyc}, 64'd5);
    check("perf_redir", {32'd0, perf_redirects}, 64'd2);
    drive(1, 0, 32'h0, 0, 0);
    drive(0, 0, 32'h0, 0, 0);
    check("perf_stall_clr", {32'd0, perf_stall_cyc}, 64'd0);
    check("perf_redir_clr", {32'd0, perf_redirects}, 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
